// File: rtl/servo_angle_ramp.sv
// servo_angle_ramp: multi-channel servo angle stepper driven by an up/down key pair.
// Define SERVO_RAMP_TARGET_EN to add the valid/ready target port with autonomous ramping.
module servo_angle_ramp #(
  parameter int N_CH = 4,
  parameter int ANGLE_W = 8,
  parameter int MIN_ANGLE = 0,
  parameter int MAX_ANGLE = 180,
  parameter int RESET_ANGLE = 90,
  parameter int STEP = 1,
  parameter int TICK_W = 22,
  localparam int SEL_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [1:0]              iKey,
  input  logic [1:0]              iSW,
  input  logic [SEL_W-1:0]        iSel,
  input  logic                    iTgtValid,
  input  logic [SEL_W-1:0]        iTgtCh,
  input  logic [ANGLE_W-1:0]      iTgtAngle,
  output logic                    oTgtReady,
  output logic [N_CH*ANGLE_W-1:0] oAngle,
  output logic [N_CH-1:0]         oBusy
);
  localparam logic [ANGLE_W:0] MIN_V = (ANGLE_W+1)'(MIN_ANGLE);
  localparam logic [ANGLE_W:0] MAX_V = (ANGLE_W+1)'(MAX_ANGLE);
  localparam logic [ANGLE_W:0] STEP_V = (ANGLE_W+1)'(STEP);
  localparam logic [ANGLE_W-1:0] RESET_V = ANGLE_W'(RESET_ANGLE);
  logic keyUp, keyDn, keyAct, mTick;
  logic [TICK_W-1:0] mCnt, inc;
  assign keyUp = iKey == 2'b10;
  assign keyDn = iKey == 2'b01;
  assign keyAct = keyUp | keyDn;
  assign inc = TICK_W'(iSW) + TICK_W'(1);
  assign mTick = keyAct & mCnt[TICK_W-1];
  always_ff @(posedge iClk)
    mCnt <= (iRst || !keyAct || mTick) ? '0 : mCnt + inc;
`ifdef SERVO_RAMP_TARGET_EN
  logic [TICK_W-1:0] rCnt;
  logic anyBusy, rTick, accept;
  logic [ANGLE_W-1:0] tgtClamp;
  assign anyBusy = |oBusy;
  assign rTick = anyBusy & rCnt[TICK_W-1];
  always_ff @(posedge iClk)
    rCnt <= (iRst || !anyBusy || rTick) ? '0 : rCnt + inc;
  // The key owner of a channel wins; a target for it is refused rather than dropped.
  assign oTgtReady = !iRst && (32'(iTgtCh) < N_CH) && !(keyAct && iTgtCh == iSel);
  assign accept = iTgtValid & oTgtReady;
  assign tgtClamp = ANGLE_W'({1'b0, iTgtAngle} > MAX_V ? MAX_V :
                             {1'b0, iTgtAngle} < MIN_V ? MIN_V : {1'b0, iTgtAngle});
`else
  logic unusedTgt;
  assign unusedTgt = ^{iTgtValid, iTgtCh, iTgtAngle};
  assign oTgtReady = 1'b0;
  assign oBusy = '0;
`endif
  for (genvar k = 0; k < N_CH; k++) begin : gCh
    logic [ANGLE_W-1:0] ang, upV, dnV;
    logic [ANGLE_W:0] a;
    logic here;
    assign a = {1'b0, ang};
    assign here = keyAct && iSel == SEL_W'(k);
    assign upV = ANGLE_W'(a + STEP_V > MAX_V ? MAX_V : a + STEP_V);
    assign dnV = ANGLE_W'(a - MIN_V < STEP_V ? MIN_V : a - STEP_V);
    assign oAngle[k*ANGLE_W +: ANGLE_W] = ang;
`ifdef SERVO_RAMP_TARGET_EN
    logic [ANGLE_W-1:0] tgt, rampV;
    logic [ANGLE_W:0] t;
    logic busy, acc;
    assign t = {1'b0, tgt};
    assign acc = accept && iTgtCh == SEL_W'(k);
    assign rampV = ANGLE_W'(t > a ? (t - a <= STEP_V ? t : a + STEP_V)
                                  : (a - t <= STEP_V ? t : a - STEP_V));
    assign oBusy[k] = busy;
    always_ff @(posedge iClk)
      if (iRst) begin
        busy <= 1'b0;
        tgt <= RESET_V;
      end else if (here) busy <= 1'b0;
      else if (acc) begin
        tgt <= tgtClamp;
        busy <= tgtClamp != ang;
      end else if (busy && rTick && rampV == tgt) busy <= 1'b0;
`endif
    always_ff @(posedge iClk)
      if (iRst) ang <= RESET_V;
      else if (here && mTick) ang <= keyUp ? upV : dnV;
`ifdef SERVO_RAMP_TARGET_EN
      else if (!acc && busy && rTick) ang <= rampV;
`endif
  end
endmodule

// File: tb/tb_servo_angle_ramp.sv
// tb_servo_angle_ramp: directed and random stimulus against a behavioural angle model.
module tb_servo_angle_ramp;
  localparam int HALF = 8, MINA = 0, MAXA = 180, RA = 90, STEP = 1;
`ifdef SERVO_RAMP_TARGET_EN
  localparam bit TGT = 1'b1;
`else
  localparam bit TGT = 1'b0;
`endif
  logic iClk = 1'b0, iRst = 1'b1, iSel = 1'b0, iTgtValid = 1'b0, iTgtCh = 1'b0;
  logic [1:0] iKey = 2'b11, iSW = 2'b00;
  logic [7:0] iTgtAngle = 8'd0;
  logic oTgtReady, lastRdy;
  logic [15:0] oAngle;
  logic [1:0] oBusy;
  int total = 0, bad = 0;
  int mAng[2] = '{RA, RA}, mTgt[2] = '{RA, RA};
  bit mBusy[2] = '{1'b0, 1'b0};
  int mAcc = 0, rAcc = 0;

  servo_angle_ramp #(.N_CH(2), .ANGLE_W(8), .MIN_ANGLE(MINA), .MAX_ANGLE(MAXA),
    .RESET_ANGLE(RA), .STEP(STEP), .TICK_W(4)) dut (
    .iClk(iClk), .iRst(iRst), .iKey(iKey), .iSW(iSW), .iSel(iSel),
    .iTgtValid(iTgtValid), .iTgtCh(iTgtCh), .iTgtAngle(iTgtAngle),
    .oTgtReady(oTgtReady), .oAngle(oAngle), .oBusy(oBusy));

  always #5 iClk = ~iClk;

  task automatic checkVal(string tag, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit modelReady();
    bit act = iKey == 2'b10 || iKey == 2'b01;
    return TGT && !iRst && !(act && iTgtCh == iSel);
  endfunction

  // Next-state of the behavioural model from the inputs present before the edge.
  task automatic modelEdge();
    bit up = iKey == 2'b10, act = iKey == 2'b10 || iKey == 2'b01, rdy = modelReady();
    bit anyB = mBusy[0] || mBusy[1];
    bit mT = act && mAcc >= HALF, rT = anyB && rAcc >= HALF;
    int t, d;
    if (iRst) begin
      mAng = '{RA, RA}; mTgt = '{RA, RA}; mBusy = '{1'b0, 1'b0}; mAcc = 0; rAcc = 0;
      return;
    end
    mAcc = (!act || mT) ? 0 : mAcc + int'(iSW) + 1;
    rAcc = (!anyB || rT) ? 0 : rAcc + int'(iSW) + 1;
    for (int c = 0; c < 2; c++) begin
      if (act && int'(iSel) == c) begin
        mBusy[c] = 1'b0;
        if (mT) mAng[c] = up ? (mAng[c] + STEP > MAXA ? MAXA : mAng[c] + STEP)
                             : (mAng[c] - STEP < MINA ? MINA : mAng[c] - STEP);
      end else if (rdy && iTgtValid && int'(iTgtCh) == c) begin
        t = int'(iTgtAngle);
        t = t > MAXA ? MAXA : t < MINA ? MINA : t;
        mTgt[c] = t;
        mBusy[c] = t != mAng[c];
      end else if (mBusy[c] && rT) begin
        d = mTgt[c] - mAng[c];
        if (d <= STEP && d >= -STEP) begin
          mAng[c] = mTgt[c];
          mBusy[c] = 1'b0;
        end else mAng[c] += d > 0 ? STEP : -STEP;
      end
    end
  endtask

  // One clock: drive at the falling edge, check ready, advance model, check registered outputs.
  task automatic cyc(logic [1:0] key, logic sel, logic [1:0] sw, logic v, logic ch,
                     logic [7:0] ang, logic rst);
    iKey = key; iSel = sel; iSW = sw; iTgtValid = v; iTgtCh = ch; iTgtAngle = ang; iRst = rst;
    #1;
    lastRdy = oTgtReady;
    checkVal("ready", oTgtReady, modelReady());
    modelEdge();
    @(negedge iClk);
    checkVal("ang0", oAngle[7:0], mAng[0]);
    checkVal("ang1", oAngle[15:8], mAng[1]);
    checkVal("busy", oBusy, {mBusy[1], mBusy[0]});
  endtask

  task automatic idle(int n, logic [1:0] sw);
    for (int i = 0; i < n; i++) cyc(2'b11, 1'b0, sw, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    logic [1:0] key, sw;
    logic sel;
    int len;
    @(negedge iClk);
    cyc(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0, 1'b1);
    checkVal("rstReady", lastRdy, 0);
    cyc(2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 8'd10, 1'b1);
    checkVal("rstAng", oAngle, {8'd90, 8'd90});
    checkVal("rstBusy", oBusy, 0);
    for (int i = 0; i < 90; i++) cyc(2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 8'd0, 1'b0);
    checkVal("manualUp", oAngle, {8'd100, 8'd90});
    idle(10, 2'b00);
    checkVal("holdIdle", oAngle[15:8], 100);
    for (int i = 0; i < 300; i++) cyc(2'b10, 1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
    checkVal("satMax", oAngle[7:0], 180);
    for (int i = 0; i < 600; i++) cyc(2'b01, 1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
    checkVal("satMin", oAngle[7:0], 0);
`ifdef SERVO_RAMP_TARGET_EN
    cyc(2'b11, 1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 1'b1);
    cyc(2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 8'd95, 1'b0);
    checkVal("accBusy", oBusy, 2'b01);
    idle(14, 2'b11);
    checkVal("ramp94", oAngle[7:0], 94);
    checkVal("ramp94busy", oBusy, 2'b01);
    idle(1, 2'b11);
    checkVal("ramp95", oAngle[7:0], 95);
    checkVal("ramp95busy", oBusy, 2'b00);
    cyc(2'b11, 1'b0, 2'b11, 1'b1, 1'b1, 8'd250, 1'b0);
    idle(280, 2'b11);
    checkVal("clamp180", oAngle[15:8], 180);
    cyc(2'b11, 1'b0, 2'b11, 1'b1, 1'b1, 8'd0, 1'b0);
    idle(30, 2'b11);
    checkVal("busy1", oBusy, 2'b10);
    cyc(2'b01, 1'b1, 2'b11, 1'b1, 1'b1, 8'd77, 1'b0);
    checkVal("keyBlocksTgt", lastRdy, 0);
    checkVal("keyCancels", oBusy[1], 0);
    for (int i = 0; i < 9; i++) cyc(2'b01, 1'b1, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
    checkVal("manualAfterCancel", oAngle[15:8], 167);
`else
    for (int i = 0; i < 5; i++) cyc(2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 8'd10, 1'b0);
    checkVal("noTgtReady", lastRdy, 0);
    checkVal("noTgtBusy", oBusy, 0);
    checkVal("noTgtAng", oAngle, {8'd100, 8'd0});
`endif
    for (int s = 0; s < 70; s++) begin
      case ($urandom_range(0, 5))
        0: key = 2'b00;
        1: key = 2'b10;
        2: key = 2'b01;
        default: key = 2'b11;
      endcase
      sel = 1'($urandom);
      sw = 2'($urandom);
      len = $urandom_range(5, 120);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 19) == 0) sw = 2'($urandom);
        cyc(key, sel, sw, $urandom_range(0, 7) == 0, 1'($urandom), 8'($urandom),
            $urandom_range(0, 399) == 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
